// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, NOP constant and IF/ID record for the fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {REQ, WAIT, BUF, DROP} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bundle between fetch and imem
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  modport master (output imem_req_valid, imem_addr, input imem_req_ready, imem_rvalid, imem_rdata);
  modport slave (input imem_req_valid, imem_addr, output imem_req_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats stall, stall beats load, idle advance loads a bubble
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   stall,
  input  logic   flush,
  input  logic   take,
  input  if_id_t d,
  output if_id_t if_id_q
);
  localparam if_id_t BUBBLE = '{instr: BUBBLE_INSTR, pc: 32'd0, pcplus4: 32'd0, valid: 1'b0};
  if_id_t if_id_d;
  always_comb if_id_d = flush ? BUBBLE : stall ? if_id_q : take ? d : BUBBLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) if_id_q <= BUBBLE;
    else if_id_q <= if_id_d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns PCF, issues single-outstanding imem requests and feeds the IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StallF,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          PCSrcE,
  input  logic [31:0]   PCTargetE,
  fetch_stage_if.master imem,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCD,
  output logic [31:0]   PCPlus4D,
  output logic          ValidD,
  output logic          FetchBusyF
);
  import fetch_pkg::*;
  fetch_state_t state_q, state_d;
  logic [31:0] pcf_q, pcf_d, buf_instr_q, buf_instr_d, buf_pc_q, buf_pc_d, in_pc;
  logic hs, resp, avail, take, leave;
  if_id_t in_d, if_id_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= REQ;
      pcf_q       <= RESET_PC;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  // leave: the held/arriving instruction is consumed or discarded this cycle
  always_comb begin
    hs    = imem.imem_req_valid & imem.imem_req_ready;
    resp  = (state_q == WAIT) & imem.imem_rvalid;
    avail = resp | (state_q == BUF);
    take  = avail & !PCSrcE;
    leave = PCSrcE | FlushD | !StallD;
    in_pc = resp ? pcf_q : buf_pc_q;
    in_d  = '{instr: resp ? imem.imem_rdata : buf_instr_q, pc: in_pc, pcplus4: in_pc + 32'd4, valid: 1'b1};
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ:     state_d = hs ? (PCSrcE ? DROP : WAIT) : REQ;
      WAIT:    state_d = imem.imem_rvalid ? (leave ? REQ : BUF) : (PCSrcE ? DROP : WAIT);
      BUF:     state_d = leave ? REQ : BUF;
      DROP:    state_d = imem.imem_rvalid ? REQ : DROP;
      default: state_d = REQ;
    endcase
    pcf_d       = PCSrcE ? PCTargetE : (take & !StallD & !FlushD) ? pcf_q + 32'd4 : pcf_q;
    buf_instr_d = (resp & !leave) ? imem.imem_rdata : buf_instr_q;
    buf_pc_d    = (resp & !leave) ? pcf_q : buf_pc_q;
  end
  always_comb begin
    imem.imem_req_valid = (state_q == REQ) & !StallF & !reset;
    imem.imem_addr      = pcf_q;
    FetchBusyF          = !avail;
  end
  if_id_reg #(.BUBBLE_INSTR(NOP_INSTR)) u_if_id (
    .clk, .reset, .stall(StallD), .flush(FlushD), .take, .d(in_d), .if_id_q
  );
  assign {InstrD, PCD, PCPlus4D, ValidD} = if_id_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed fetch scenarios plus randomized hazards checked against a program-order model
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, reset = 1, StallF = 0, StallD = 0, FlushD = 0, PCSrcE = 0;
  logic [31:0] PCTargetE = 0, InstrD, PCD, PCPlus4D;
  logic ValidD, FetchBusyF;
  fetch_stage_if mi();
  fetch_stage dut (
    .clk, .reset, .StallF, .StallD, .FlushD, .PCSrcE, .PCTargetE, .imem(mi),
    .InstrD, .PCD, .PCPlus4D, .ValidD, .FetchBusyF
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0, cyc = 0, due = -1, lat = 1;
  bit rand_rdy = 0, rand_lat = 0;
  logic [31:0] due_addr = 0, p_addr, p_target;
  logic p_hs, p_reqv, p_busy, p_stallD, p_flushD, p_pcsrc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h00a0_0113 : {a[31:2] ^ 30'h1555_AAAA, 2'b11};
  endfunction

  // one clock: memory drives at negedge, pre-edge values are latched into p_*, returns at posedge+1
  task automatic step();
    @(negedge clk);
    mi.imem_rvalid    = !reset && due == cyc;
    mi.imem_rdata     = (due == cyc) ? mem_word(due_addr) : 32'hDEAD_BEEF;
    mi.imem_req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    p_hs = mi.imem_req_valid & mi.imem_req_ready;
    p_reqv = mi.imem_req_valid; p_addr = mi.imem_addr; p_busy = FetchBusyF;
    p_stallD = StallD; p_flushD = FlushD; p_pcsrc = PCSrcE; p_target = PCTargetE;
    if (p_hs) begin due = cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat); due_addr = p_addr; end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1; step(); step();
    n_cmp++; if (p_reqv !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", p_reqv); end
    n_cmp++; if ({InstrD, PCD, PCPlus4D, ValidD} !== {NOP, 64'd0, 1'b0}) begin n_err++; $display("FAIL reset_ifid got %h %h %h %b", InstrD, PCD, PCPlus4D, ValidD); end
    n_cmp++; if (mi.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", mi.imem_addr); end
    reset = 0;
  endtask

  task automatic test_basic();
    step();
    n_cmp++; if ({p_hs, p_addr, p_busy} !== {1'b1, 32'h0, 1'b1}) begin n_err++; $display("FAIL basic_req0 got hs=%b addr=%h busy=%b", p_hs, p_addr, p_busy); end
    step();
    n_cmp++; if (p_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy got %b want 0", p_busy); end
    n_cmp++; if ({InstrD, PCD, PCPlus4D, ValidD} !== {32'h0050_0093, 32'h0, 32'h4, 1'b1}) begin n_err++; $display("FAIL basic_i0 got %h %h %h %b", InstrD, PCD, PCPlus4D, ValidD); end
    step();
    n_cmp++; if ({p_hs, p_addr, InstrD, ValidD} !== {1'b1, 32'h4, NOP, 1'b0}) begin n_err++; $display("FAIL basic_bubble got hs=%b addr=%h instr=%h v=%b", p_hs, p_addr, InstrD, ValidD); end
    step();
    n_cmp++; if ({InstrD, PCD, PCPlus4D, ValidD} !== {32'h00a0_0113, 32'h4, 32'h8, 1'b1}) begin n_err++; $display("FAIL basic_i1 got %h %h %h %b", InstrD, PCD, PCPlus4D, ValidD); end
  endtask

  task automatic test_stall();
    StallD = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if ({InstrD, PCD, PCPlus4D, ValidD} !== {32'h00a0_0113, 32'h4, 32'h8, 1'b1}) begin n_err++; $display("FAIL stall_hold%0d got %h %h %h %b", i, InstrD, PCD, PCPlus4D, ValidD); end
      if (i == 0) begin n_cmp++; if ({p_hs, p_addr} !== {1'b1, 32'h8}) begin n_err++; $display("FAIL stall_req got hs=%b addr=%h want 1 8", p_hs, p_addr); end end
      if (i > 0) begin n_cmp++; if (p_busy !== 1'b0) begin n_err++; $display("FAIL stall_busy%0d got %b want 0", i, p_busy); end end
    end
    StallD = 0; step();
    n_cmp++; if ({InstrD, PCD, PCPlus4D, ValidD, mi.imem_addr} !== {mem_word(32'h8), 32'h8, 32'hC, 1'b1, 32'hC}) begin n_err++; $display("FAIL stall_release got %h %h %h %b pcf=%h", InstrD, PCD, PCPlus4D, ValidD, mi.imem_addr); end
  endtask

  task automatic test_redirect();
    int k; bit bad;
    lat = 2; k = 0; bad = 0;
    do begin step(); k++; end while (!(p_hs && p_addr == 32'h10) && k < 30);
    n_cmp++; if (!(p_hs && p_addr == 32'h10)) begin n_err++; $display("FAIL redir_req10 got hs=%b addr=%h", p_hs, p_addr); end
    PCTargetE = 32'h100; PCSrcE = 1; step(); PCSrcE = 0; k = 0;
    do begin step(); k++; if (ValidD && PCD == 32'h10) bad = 1; end while (!p_hs && k < 20);
    n_cmp++; if ({p_hs, p_addr} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL redir_addr got hs=%b addr=%h want 100", p_hs, p_addr); end
    k = 0;
    do begin step(); k++; if (ValidD && PCD == 32'h10) bad = 1; end while (!ValidD && k < 20);
    n_cmp++; if ({ValidD, PCD, InstrD} !== {1'b1, 32'h100, mem_word(32'h100)}) begin n_err++; $display("FAIL redir_pcd got v=%b pcd=%h instr=%h", ValidD, PCD, InstrD); end
    n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL redir_dropped got stale 0x10 delivered=%b want 0", bad); end
  endtask

  task automatic test_flush();
    int k; logic [31:0] a;
    lat = 1; k = 0;
    do begin step(); k++; end while (!p_hs && k < 20);
    a = p_addr; FlushD = 1; StallD = 1; step();
    n_cmp++; if ({InstrD, PCD, PCPlus4D, ValidD} !== {NOP, 64'd0, 1'b0}) begin n_err++; $display("FAIL flush_ifid got %h %h %h %b", InstrD, PCD, PCPlus4D, ValidD); end
    FlushD = 0; StallD = 0; k = 0;
    do begin step(); k++; end while (!ValidD && k < 20);
    n_cmp++; if ({ValidD, PCD, InstrD} !== {1'b1, a, mem_word(a)}) begin n_err++; $display("FAIL flush_refetch got v=%b pcd=%h instr=%h want pcd=%h", ValidD, PCD, InstrD, a); end
  endtask

  task automatic test_stallf();
    int k; bit bad; logic [31:0] a;
    lat = 3; k = 0; bad = 0;
    do begin step(); k++; end while (!p_hs && k < 20);
    a = p_addr; StallF = 1; k = 0;
    do begin step(); k++; if (p_reqv) bad = 1; end while (!ValidD && k < 20);
    n_cmp++; if ({ValidD, PCD, InstrD} !== {1'b1, a, mem_word(a)}) begin n_err++; $display("FAIL stallf_capture got v=%b pcd=%h instr=%h want pcd=%h", ValidD, PCD, InstrD, a); end
    step(); step();
    n_cmp++; if ({bad, p_reqv, mi.imem_addr} !== {1'b0, 1'b0, a + 32'd4}) begin n_err++; $display("FAIL stallf_hold got req_seen=%b reqv=%b pcf=%h want pcf=%h", bad, p_reqv, mi.imem_addr, a + 32'd4); end
    StallF = 0; step();
    n_cmp++; if ({p_hs, p_addr} !== {1'b1, a + 32'd4}) begin n_err++; $display("FAIL stallf_resume got hs=%b addr=%h", p_hs, p_addr); end
  endtask

  task automatic test_reset_mid();
    int k;
    lat = 3; PCTargetE = 32'h40; PCSrcE = 1; step(); PCSrcE = 0; k = 0;
    do begin step(); k++; end while (!(p_hs && p_addr == 32'h40) && k < 30);
    n_cmp++; if (!(p_hs && p_addr == 32'h40)) begin n_err++; $display("FAIL rstmid_req40 got hs=%b addr=%h", p_hs, p_addr); end
    step();
    #2 reset = 1; due = -1; #1;
    n_cmp++; if ({InstrD, PCD, PCPlus4D, ValidD, mi.imem_req_valid, mi.imem_addr} !== {NOP, 64'd0, 1'b0, 1'b0, 32'h0}) begin n_err++; $display("FAIL rstmid_async got %h %h %h %b reqv=%b pcf=%h", InstrD, PCD, PCPlus4D, ValidD, mi.imem_req_valid, mi.imem_addr); end
    step();
    n_cmp++; if (p_reqv !== 1'b0) begin n_err++; $display("FAIL rstmid_reqv got %b want 0", p_reqv); end
    reset = 0; step();
    n_cmp++; if ({p_hs, p_addr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL rstmid_first got hs=%b addr=%h want 1 0", p_hs, p_addr); end
    k = 0;
    do begin step(); k++; end while (!ValidD && k < 20);
    lat = 1; PCTargetE = 32'hFFFF_FFFC; PCSrcE = 1; step(); PCSrcE = 0; k = 0;
    do begin step(); k++; end while (!ValidD && k < 20);
    n_cmp++; if ({PCD, PCPlus4D, mi.imem_addr} !== {32'hFFFF_FFFC, 32'h0, 32'h0}) begin n_err++; $display("FAIL wrap got pcd=%h pcplus4=%h pcf=%h", PCD, PCPlus4D, mi.imem_addr); end
  endtask

  // reference: instructions must leave fetch in program order, restarting at every redirect target
  task automatic test_random();
    logic [31:0] exp_pc, h_i, h_p, h_p4; logic h_v; int deliv;
    deliv = 0; rand_rdy = 1; rand_lat = 1;
    PCTargetE = 32'h2000; PCSrcE = 1; step(); PCSrcE = 0;
    exp_pc = 32'h2000;
    for (int i = 0; i < 1500; i++) begin
      StallF = ($urandom_range(0, 4) == 0); StallD = ($urandom_range(0, 3) == 0);
      FlushD = ($urandom_range(0, 11) == 0); PCSrcE = ($urandom_range(0, 19) == 0);
      PCTargetE = $urandom();
      {h_i, h_p, h_p4, h_v} = {InstrD, PCD, PCPlus4D, ValidD};
      step();
      if (p_reqv) begin n_cmp++; if (p_addr !== exp_pc) begin n_err++; $display("FAIL rand_addr cyc=%0d got %h want %h", cyc, p_addr, exp_pc); end end
      if (p_flushD) begin
        n_cmp++; if ({InstrD, PCD, PCPlus4D, ValidD} !== {NOP, 64'd0, 1'b0}) begin n_err++; $display("FAIL rand_flush cyc=%0d got %h %h %h %b", cyc, InstrD, PCD, PCPlus4D, ValidD); end
      end else if (p_stallD) begin
        n_cmp++; if ({InstrD, PCD, PCPlus4D, ValidD} !== {h_i, h_p, h_p4, h_v}) begin n_err++; $display("FAIL rand_hold cyc=%0d got %h %h want %h %h", cyc, InstrD, PCD, h_i, h_p); end
      end else if (p_pcsrc) begin
        n_cmp++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL rand_redir_kill cyc=%0d got v=%b pcd=%h", cyc, ValidD, PCD); end
      end else begin
        n_cmp++; if (ValidD !== !p_busy) begin n_err++; $display("FAIL rand_busy cyc=%0d got v=%b busy=%b", cyc, ValidD, p_busy); end
        if (ValidD) begin
          n_cmp++; if ({PCD, InstrD, PCPlus4D} !== {exp_pc, mem_word(exp_pc), exp_pc + 32'd4}) begin n_err++; $display("FAIL rand_order cyc=%0d got pcd=%h instr=%h want pcd=%h", cyc, PCD, InstrD, exp_pc); end
          exp_pc += 32'd4; deliv++;
        end
      end
      if (p_pcsrc) exp_pc = p_target;
    end
    n_cmp++; if (deliv < 30) begin n_err++; $display("FAIL rand_progress got %0d deliveries want >=30", deliv); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    mi.imem_req_ready = 0; mi.imem_rvalid = 0; mi.imem_rdata = 0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_flush();
    test_stallf();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
